alu_result_merge: RTL and testbench

//  Sits directly downstream of the per-container ALU array in an RMT action stage.

---
 rtl/alu_result_merge_pkg.sv | 31 +++
 rtl/alu_result_merge_lane.sv | 58 +++++
 rtl/alu_result_merge.sv | 149 ++++++++++++++
 tb/tb_alu_result_merge.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_result_merge_pkg.sv
// Shared definitions for the ALU result merge stage: default geometry,
// PHV length formula, FSM state encoding and small arithmetic helpers.
package alu_result_merge_pkg;

    // Total PHV width: containers packed from bit 0 upward, metadata on top.
    function automatic int phv_len(input int num_alu, input int data_width, input int meta_width);
        return num_alu * data_width + meta_width;
    endfunction

    localparam int DEF_NUM_ALU    = 8;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_META_WIDTH = 256;
    localparam int DEF_TIMEOUT    = 15;
    localparam int DEF_PHV_LEN    = phv_len(DEF_NUM_ALU, DEF_DATA_WIDTH, DEF_META_WIDTH);

    localparam int TIMER_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_OUTPUT  = 2'd2
    } state_e;

    // 16-bit add that sticks at all-ones instead of wrapping.
    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/alu_result_merge_lane.sv
// One container slot of the merge buffer: holds the slot value and whether
// this lane's ALU result has already arrived for the PHV in flight.
module alu_result_merge_lane #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,     // PHV accepted this cycle
    input  logic                  capture_i,  // collection window open
    input  logic                  strobe_i,   // ALU result valid
    input  logic [DATA_WIDTH-1:0] phv_slot_i,
    input  logic [DATA_WIDTH-1:0] result_i,
    output logic [DATA_WIDTH-1:0] slot_o,
    output logic                  arrived_o,
    output logic                  stray_o     // strobe dropped this cycle
);

    logic [DATA_WIDTH-1:0] slot_q, slot_d;
    logic                  arrived_q, arrived_d;
    logic                  stray_s;

    // Decide slot contents: a strobe in the accept cycle overrides the PHV value,
    // only the first strobe per PHV is taken, everything else is dropped.
    always_comb begin
        slot_d    = slot_q;
        arrived_d = arrived_q;
        stray_s   = 1'b0;
        if (load_i) begin
            arrived_d = strobe_i;
            slot_d    = strobe_i ? result_i : phv_slot_i;
        end else if (capture_i) begin
            if (strobe_i && !arrived_q) begin
                slot_d    = result_i;
                arrived_d = 1'b1;
            end else begin
                stray_s = strobe_i;
            end
        end else begin
            stray_s = strobe_i;
        end
    end

    // Slot and arrival flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q    <= {DATA_WIDTH{1'b0}};
            arrived_q <= 1'b0;
        end else begin
            slot_q    <= slot_d;
            arrived_q <= arrived_d;
        end
    end

    assign slot_o    = slot_q;
    assign arrived_o = arrived_q;
    assign stray_o   = stray_s;

endmodule

// File: rtl/alu_result_merge.sv
// Merges per-container ALU results back into the PHV launched with an action
// and hands the rebuilt PHV downstream over valid/ready.
module alu_result_merge
    import alu_result_merge_pkg::*;
#(
    parameter int  NUM_ALU    = DEF_NUM_ALU,
    parameter int  DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int  META_WIDTH = DEF_META_WIDTH,
    parameter int  TIMEOUT    = DEF_TIMEOUT,
    localparam int PHV_LEN    = phv_len(NUM_ALU, DATA_WIDTH, META_WIDTH)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PHV_LEN-1:0]            phv_in,
    input  logic                          phv_valid_in,
    output logic                          phv_ready_out,
    input  logic [NUM_ALU*DATA_WIDTH-1:0] container_in,
    input  logic [NUM_ALU-1:0]            container_valid_in,
    output logic [PHV_LEN-1:0]            phv_out,
    output logic                          phv_valid_out,
    input  logic                          phv_ready_in,
    output logic                          timeout_err,
    output logic [15:0]                   stray_cnt
);

    localparam logic [TIMER_W-1:0] TIMEOUT_C = TIMER_W'(TIMEOUT);
    localparam logic [TIMER_W-1:0] TIMER_MAX = {TIMER_W{1'b1}};

    function automatic logic [15:0] popcount(input logic [NUM_ALU-1:0] v);
        logic [15:0] n;
        n = 16'd0;
        for (int i = 0; i < NUM_ALU; i++) begin
            n = n + {15'd0, v[i]};
        end
        return n;
    endfunction

    state_e                    state_q, state_d;
    logic [TIMER_W-1:0]        timer_q, timer_d;
    logic [META_WIDTH-1:0]     meta_q, meta_d;
    logic [15:0]               stray_q, stray_d;
    logic                      tmo_q, tmo_d;
    logic                      valid_q, valid_d;

    logic                      load_s, capture_s, all_in_s;
    logic [NUM_ALU-1:0]        arrived_s, stray_s;
    logic [NUM_ALU*DATA_WIDTH-1:0] slots_s;

    assign load_s    = (state_q == ST_IDLE) && phv_valid_in;
    assign capture_s = (state_q == ST_COLLECT);
    // Mask as it will be after this cycle's captures.
    assign all_in_s  = &(arrived_s | container_valid_in);

    for (genvar i = 0; i < NUM_ALU; i++) begin : g_lane
        alu_result_merge_lane #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .load_i     (load_s),
            .capture_i  (capture_s),
            .strobe_i   (container_valid_in[i]),
            .phv_slot_i (phv_in[i*DATA_WIDTH +: DATA_WIDTH]),
            .result_i   (container_in[i*DATA_WIDTH +: DATA_WIDTH]),
            .slot_o     (slots_s[i*DATA_WIDTH +: DATA_WIDTH]),
            .arrived_o  (arrived_s[i]),
            .stray_o    (stray_s[i])
        );
    end

    // Next-state logic: accept in IDLE, wait for all lanes or the timer in
    // COLLECT, hold the merged PHV in OUTPUT until downstream takes it.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        meta_d  = meta_q;
        tmo_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (phv_valid_in) begin
                    state_d = ST_COLLECT;
                    timer_d = {TIMER_W{1'b0}};
                    meta_d  = phv_in[PHV_LEN-1 -: META_WIDTH];
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (all_in_s) begin
                    // Completion wins over a coincident timeout.
                    state_d = ST_OUTPUT;
                end else if (timer_q == TIMEOUT_C) begin
                    state_d = ST_OUTPUT;
                    tmo_d   = 1'b1;
                end else if (timer_q != TIMER_MAX) begin
                    timer_d = timer_q + 4'd1;
                end else begin
                    timer_d = timer_q;
                end
            end
            ST_OUTPUT: begin
                if (phv_ready_in) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_OUTPUT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Dropped strobes accumulate into a saturating counter.
    always_comb begin
        stray_d = sat_add16(stray_q, popcount(stray_s));
    end

    // Output valid follows the state being entered so it is a clean register.
    always_comb begin
        valid_d = (state_d == ST_OUTPUT);
    end

    // Control and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            timer_q <= {TIMER_W{1'b0}};
            meta_q  <= {META_WIDTH{1'b0}};
            stray_q <= 16'd0;
            tmo_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            meta_q  <= meta_d;
            stray_q <= stray_d;
            tmo_q   <= tmo_d;
            valid_q <= valid_d;
        end
    end

    assign phv_out       = {meta_q, slots_s};
    assign phv_valid_out = valid_q;
    assign phv_ready_out = (state_q == ST_IDLE) && !rst;
    assign timeout_err   = tmo_q;
    assign stray_cnt     = stray_q;

endmodule

// File: tb/tb_alu_result_merge.sv
// Scoreboard bench for alu_result_merge: stimulus computes each expected PHV
// from a per-cycle strobe schedule; a monitor checks whatever the DUT emits.
module tb_alu_result_merge;
    import alu_result_merge_pkg::*;

    localparam int N   = DEF_NUM_ALU;
    localparam int DW  = DEF_DATA_WIDTH;
    localparam int MW  = DEF_META_WIDTH;
    localparam int PL  = DEF_PHV_LEN;
    localparam int TMO = DEF_TIMEOUT;
    localparam int SCH = 40;

    logic            clk = 1'b0;
    logic            rst;
    logic [PL-1:0]   phv_in;
    logic            phv_valid_in;
    logic            phv_ready_out;
    logic [N*DW-1:0] container_in;
    logic [N-1:0]    container_valid_in;
    logic [PL-1:0]   phv_out;
    logic            phv_valid_out;
    logic            phv_ready_in;
    logic            timeout_err;
    logic [15:0]     stray_cnt;

    alu_result_merge #(
        .NUM_ALU(N), .DATA_WIDTH(DW), .META_WIDTH(MW), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .phv_in(phv_in), .phv_valid_in(phv_valid_in),
        .phv_ready_out(phv_ready_out), .container_in(container_in),
        .container_valid_in(container_valid_in), .phv_out(phv_out),
        .phv_valid_out(phv_valid_out), .phv_ready_in(phv_ready_in),
        .timeout_err(timeout_err), .stray_cnt(stray_cnt)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [PL-1:0] phv;
        bit            tmo;
        int unsigned   rise;
    } exp_t;
    exp_t sb[$];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [PL-1:0] act, input logic [PL-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Strobe schedule per cycle relative to the accept cycle, and model state.
    logic [N-1:0]  sm [SCH];
    logic [DW-1:0] sv [SCH][N];
    logic [PL-1:0] txn_phv;
    int unsigned   m_stray = 0;

    task automatic add_stray(input int n);
        m_stray = (m_stray + n > 65535) ? 65535 : m_stray + n;
    endtask

    task automatic clear_sched();
        for (int c = 0; c < SCH; c++) begin
            sm[c] = '0;
            for (int l = 0; l < N; l++) sv[c][l] = '0;
        end
    endtask

    task automatic strobe(input int c, input int l, input logic [DW-1:0] v);
        sm[c][l] = 1'b1;
        sv[c][l] = v;
    endtask

    task automatic gen_phv();
        for (int w = 0; w < PL / 32; w++) txn_phv[w*32 +: 32] = $urandom;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic zero_inputs();
        phv_valid_in       = 1'b0;
        container_valid_in = '0;
        container_in       = '0;
        phv_ready_in       = 1'b0;
    endtask

    // Reference: first strobe per lane wins while the window is open; the window
    // ends when every lane has a result (from cycle 1 on) or at cycle TMO+1.
    task automatic run_txn(input int hold, input int idle_cycles, input bit idle_strays);
        logic [PL-1:0]   e;
        logic [N-1:0]    mask;
        logic [N*DW-1:0] ci;
        int              close;
        int              last;
        bit              tmo;
        exp_t            x;
        e     = txn_phv;
        mask  = '0;
        close = TMO + 1;
        tmo   = 1'b1;
        for (int c = 0; c <= TMO + 1; c++) begin
            for (int l = 0; l < N; l++) begin
                if (sm[c][l]) begin
                    if (!mask[l]) begin
                        mask[l] = 1'b1;
                        e[l*DW +: DW] = sv[c][l];
                    end else begin
                        add_stray(1);
                    end
                end
            end
            if (c >= 1 && mask == '1) begin
                close = c;
                tmo   = 1'b0;
                break;
            end
        end
        last = close + hold + 1;
        for (int c = close + 1; c <= last; c++) add_stray($countones(sm[c]));
        x.phv  = e;
        x.tmo  = tmo;
        x.rise = cyc + close + 1;
        sb.push_back(x);
        check("ready_before_accept", phv_ready_out, 1);
        for (int c = 0; c <= last; c++) begin
            for (int l = 0; l < N; l++) ci[l*DW +: DW] = sv[c][l];
            phv_in             = txn_phv;
            phv_valid_in       = (c == 0);
            container_valid_in = sm[c];
            container_in       = ci;
            phv_ready_in       = (c == last);
            step();
        end
        zero_inputs();
        for (int i = 0; i < idle_cycles; i++) begin
            phv_ready_in       = 1'($urandom);
            container_valid_in = idle_strays ? N'($urandom) : '0;
            container_in       = {$urandom, $urandom, $urandom, $urandom,
                                  $urandom, $urandom, $urandom, $urandom};
            add_stray($countones(container_valid_in));
            step();
        end
        zero_inputs();
        check("stray_cnt", stray_cnt, m_stray);
    endtask

    // Monitor: compare every presented output against the scoreboard head.
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_valid <= 1'b0;
        end else begin
            if (phv_valid_out) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", phv_valid_out, 0);
                end else begin
                    if (!prev_valid) begin
                        check("latency", cyc, sb[0].rise);
                        check("timeout_err", timeout_err, sb[0].tmo);
                    end else if (timeout_err) begin
                        check("timeout_err_late", timeout_err, 0);
                    end
                    check("phv_out", phv_out, sb[0].phv);
                    check("ready_out_in_output", phv_ready_out, 0);
                    if (phv_ready_in) void'(sb.pop_front());
                end
            end else if (timeout_err) begin
                check("timeout_err_spurious", timeout_err, 0);
            end
            prev_valid <= phv_valid_out;
        end
    end

    task automatic check_reset_values();
        check("rst_phv_out", phv_out, 0);
        check("rst_valid_out", phv_valid_out, 0);
        check("rst_ready_out", phv_ready_out, 0);
        check("rst_timeout_err", timeout_err, 0);
        check("rst_stray_cnt", stray_cnt, 0);
    endtask

    initial begin
        rst = 1'b1;
        phv_in = '0;
        zero_inputs();
        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        rst = 1'b0;
        #1;

        // 1: all strobes together three cycles after accept
        clear_sched();
        gen_phv();
        for (int i = 0; i < N; i++) begin
            txn_phv[i*DW +: DW] = DW'(i);
            strobe(3, i, DW'(32'hA0 + i));
        end
        run_txn(0, 1, 1'b0);

        // 2: staggered, lane 7 first and lane 0 last
        clear_sched();
        gen_phv();
        for (int i = 0; i < N; i++) strobe(N - i, i, $urandom);
        run_txn(0, 1, 1'b0);

        // 3: lane 7 never arrives -> forced flush
        clear_sched();
        gen_phv();
        for (int i = 0; i < N - 1; i++) strobe(2, i, $urandom);
        run_txn(0, 1, 1'b0);

        // 4: downstream stalls 5 cycles; a lane-2 strobe there is dropped
        clear_sched();
        gen_phv();
        for (int i = 0; i < N; i++) strobe(1, i, $urandom);
        strobe(3, 2, 32'hDEAD_BEEF);
        run_txn(5, 1, 1'b0);
        check("stray_after_output_strobe", stray_cnt, 1);

        // 5: duplicate lane-3 result keeps the first value
        clear_sched();
        gen_phv();
        strobe(1, 3, 32'h55);
        strobe(2, 3, 32'h66);
        for (int i = 0; i < N; i++) if (i != 3) strobe(3, i, $urandom);
        run_txn(0, 1, 1'b0);

        // 6: reset mid-collect discards the PHV
        gen_phv();
        phv_in       = txn_phv;
        phv_valid_in = 1'b1;
        step();
        phv_valid_in       = 1'b0;
        container_valid_in = 8'h0F;
        container_in       = {$urandom, $urandom, $urandom, $urandom,
                              $urandom, $urandom, $urandom, $urandom};
        step();
        zero_inputs();
        rst = 1'b1;
        #1;
        check_reset_values();
        m_stray = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        clear_sched();
        gen_phv();
        for (int i = 0; i < N; i++) strobe(1 + (i % 3), i, $urandom);
        run_txn(1, 2, 1'b0);

        // Randomized transactions with early, late, duplicate and stray strobes
        for (int t = 0; t < 40; t++) begin
            clear_sched();
            gen_phv();
            for (int l = 0; l < N; l++) begin
                if ($urandom_range(0, 9) != 0) strobe($urandom_range(0, TMO + 1), l, $urandom);
            end
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
                strobe($urandom_range(0, 24), $urandom_range(0, N - 1), $urandom);
            end
            run_txn($urandom_range(0, 4), $urandom_range(0, 2), 1'b1);
        end

        // Stray counter saturates at 0xFFFF
        for (int i = 0; i < 8200; i++) begin
            container_valid_in = '1;
            add_stray(N);
            step();
        end
        zero_inputs();
        check("stray_saturated", stray_cnt, m_stray);
        check("stray_is_max", stray_cnt, 16'hFFFF);

        for (int i = 0; i < 50 && sb.size() != 0; i++) step();
        check("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
